// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// default byte width and the width helpers used to size indices and timers.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      START     = 2'b01,
      WAIT_BUSY = 2'b10,
      WAIT_DONE = 2'b11
   } arb_state_e;

   localparam int DEFAULT_DATA_W = 8;

   // Ceiling log2: number of bits needed to count 0 .. value-1.
   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >> 1;
      end
      return result;
   endfunction

   // Index width that never collapses to zero bits.
   function automatic int idx_width(input int value);
      return (clog2(value) < 1) ? 1 : clog2(value);
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte-source and tx-path signals of the UART transmit arbiter.
// The slave modport is the arbiter's view; the master modport is the
// environment (byte sources plus the tx controller/shift register).
interface uart_tx_arbiter_if #(
   parameter int N_REQ  = 4,
   parameter int DATA_W = uart_pkg::DEFAULT_DATA_W
);
   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic [N_REQ-1:0]        req_ready;
   logic [DATA_W-1:0]       tx_data;
   logic                    tx_start;
   logic                    tx_busy;
   logic                    tx_done;

   modport master (
      output req_valid, req_data, tx_busy, tx_done,
      input  req_ready, tx_data, tx_start
   );

   modport slave (
      input  req_valid, req_data, tx_busy, tx_done,
      output req_ready, tx_data, tx_start
   );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first asserted request found when
// scanning upward from ptr (wrapping modulo N_REQ) wins.
module rr_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ = 4,
   localparam int ID_W = idx_width(N_REQ)
)(
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [ID_W-1:0]  idx,
   output logic             any
);

   // Scan from the pointer and latch onto the first requester only.
   always_comb begin
      gnt = {N_REQ{1'b0}};
      idx = {ID_W{1'b0}};
      any = 1'b0;
      for (int off = 0; off < N_REQ; off++) begin
         int   cand;
         logic hit;
         cand = int'(ptr) + off;
         cand = (cand >= N_REQ) ? (cand - N_REQ) : cand;
         hit  = (!any) && req[cand];
         gnt[cand] = gnt[cand] | hit;
         idx = hit ? ID_W'(cand) : idx;
         any = any | hit;
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART tx path among N_REQ byte sources.
// One byte is accepted at a time; the grant is held until the tx path
// reports frame completion, and a watchdog aborts a frame whose tx path
// never shows busy after tx_start.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ         = 4,
   parameter int DATA_W        = DEFAULT_DATA_W,
   parameter int START_TIMEOUT = 16,
   localparam int ID_W         = idx_width(N_REQ)
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   uart_tx_arbiter_if.slave      bus,
   output logic                  grant_valid,
   output logic [ID_W-1:0]       grant_id,
   output logic                  err_timeout
);

   localparam int TMR_W = idx_width(START_TIMEOUT);

   arb_state_e          state_r;
   logic [ID_W-1:0]     rr_ptr_r;
   logic [ID_W-1:0]     grant_id_r;
   logic [TMR_W-1:0]    timer_r;
   logic [DATA_W-1:0]   tx_data_r;
   logic                tx_start_r;
   logic                grant_valid_r;
   logic                err_timeout_r;

   logic [N_REQ-1:0]    win_gnt_s;
   logic [ID_W-1:0]     win_idx_s;
   logic                win_any_s;
   logic                offer_s;
   logic                accept_s;
   logic [ID_W-1:0]     next_ptr_s;

   rr_arbiter #(
      .N_REQ (N_REQ)
   ) u_rr (
      .req (bus.req_valid),
      .ptr (rr_ptr_r),
      .gnt (win_gnt_s),
      .idx (win_idx_s),
      .any (win_any_s)
   );

   // Offer the slot to the round-robin winner only while idle and enabled;
   // ready is also forced low while reset is held.
   always_comb begin
      offer_s       = (state_r == IDLE) && en;
      accept_s      = offer_s && win_any_s;
      bus.req_ready = (offer_s && reset) ? win_gnt_s : {N_REQ{1'b0}};
      next_ptr_s    = (win_idx_s == ID_W'(N_REQ - 1)) ? {ID_W{1'b0}}
                                                       : (win_idx_s + ID_W'(1));
   end

   // Arbiter FSM: accept, pulse start, wait for busy (watchdog), wait for done.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r       <= IDLE;
         rr_ptr_r      <= {ID_W{1'b0}};
         timer_r       <= {TMR_W{1'b0}};
         tx_data_r     <= {DATA_W{1'b0}};
         tx_start_r    <= 1'b0;
         grant_valid_r <= 1'b0;
         grant_id_r    <= {ID_W{1'b0}};
         err_timeout_r <= 1'b0;
      end else begin
         tx_start_r    <= 1'b0;
         err_timeout_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  tx_data_r     <= bus.req_data[int'(win_idx_s)*DATA_W +: DATA_W];
                  grant_id_r    <= win_idx_s;
                  grant_valid_r <= 1'b1;
                  rr_ptr_r      <= next_ptr_s;
                  tx_start_r    <= 1'b1;
                  state_r       <= START;
               end else begin
                  state_r       <= IDLE;
               end
            end
            START: begin
               timer_r <= {TMR_W{1'b0}};
               state_r <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               timer_r <= timer_r + TMR_W'(1);
               // done wins over busy so a frame with no visible busy phase still closes
               if (bus.tx_done) begin
                  grant_valid_r <= 1'b0;
                  state_r       <= IDLE;
               end else if (bus.tx_busy) begin
                  state_r       <= WAIT_DONE;
               end else if (timer_r == TMR_W'(START_TIMEOUT - 1)) begin
                  // the byte is dropped; the pointer already moved past this source
                  err_timeout_r <= 1'b1;
                  grant_valid_r <= 1'b0;
                  state_r       <= IDLE;
               end else begin
                  state_r       <= WAIT_BUSY;
               end
            end
            WAIT_DONE: begin
               if (bus.tx_done) begin
                  grant_valid_r <= 1'b0;
                  state_r       <= IDLE;
               end else begin
                  state_r       <= WAIT_DONE;
               end
            end
            default: begin
               grant_valid_r <= 1'b0;
               state_r       <= IDLE;
            end
         endcase
      end
   end

   assign bus.tx_data  = tx_data_r;
   assign bus.tx_start = tx_start_r;
   assign grant_valid  = grant_valid_r;
   assign grant_id     = grant_id_r;
   assign err_timeout  = err_timeout_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed tables, hand-written corner sequences
// and a randomized run, all compared against a transaction-level model.
module tb_uart_tx_arbiter;
   import uart_pkg::*;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int TO = 16;

   logic          clk;
   logic          reset;
   logic          en;
   logic [N-1:0]  rv;
   logic          tb_busy;
   logic          tb_done;
   logic [DW-1:0] src_data [N];
   logic          grant_valid;
   logic [1:0]    grant_id;
   logic          err_timeout;

   int n_checks = 0;
   int n_fail   = 0;

   uart_tx_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus();

   assign bus.req_valid = rv;
   assign bus.req_data  = {src_data[3], src_data[2], src_data[1], src_data[0]};
   assign bus.tx_busy   = tb_busy;
   assign bus.tx_done   = tb_done;

   uart_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .START_TIMEOUT(TO)) dut (
      .clk         (clk),
      .reset       (reset),
      .en          (en),
      .bus         (bus),
      .grant_valid (grant_valid),
      .grant_id    (grant_id),
      .err_timeout (err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: who owns the tx path, what was handed over, and how
   // long the tx path has stayed silent since the start pulse.
   int            m_owner;
   int            m_ptr;
   int            m_id;
   int            m_waited;
   int            m_last_acc;
   bit            m_start;
   bit            m_err;
   bit            m_busy_seen;
   logic [DW-1:0] m_data;

   typedef struct {
      bit            en;
      logic [3:0]    valid;
      bit            busy;
      bit            done;
      logic [3:0]    ready;
      bit            start;
      bit            gv;
      logic [1:0]    gid;
      logic [DW-1:0] data;
   } vec_t;
   vec_t tbl[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = -1; m_ptr = 0; m_id = 0; m_waited = 0; m_last_acc = -1;
      m_start = 0; m_err = 0; m_busy_seen = 0; m_data = '0;
   endtask

   function automatic int m_winner();
      if (m_owner >= 0 || en !== 1'b1 || reset !== 1'b1) return -1;
      for (int k = 0; k < N; k++) begin
         if (rv[(m_ptr + k) % N] === 1'b1) return (m_ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic model_edge();
      bit start_n;
      bit err_n;
      int w;
      start_n = 0; err_n = 0; m_last_acc = -1;
      w = m_winner();
      if (m_owner < 0) begin
         if (w >= 0) begin
            m_owner = w; m_id = w; m_data = src_data[w];
            m_ptr = (w + 1) % N; start_n = 1; m_last_acc = w;
         end
      end else if (m_start) begin
         m_waited = 0; m_busy_seen = 0;
      end else if (tb_done) begin
         m_owner = -1;
      end else if (!m_busy_seen) begin
         if (tb_busy) begin
            m_busy_seen = 1;
         end else begin
            m_waited++;
            if (m_waited == TO) begin
               err_n = 1; m_owner = -1;
            end
         end
      end
      m_start = start_n;
      m_err   = err_n;
   endtask

   task automatic settle();
      int         w;
      logic [3:0] exp_ready;
      #1;
      w = m_winner();
      exp_ready = (w >= 0) ? 4'(1 << w) : 4'b0000;
      check("cycle_outputs",
            64'({bus.req_ready, bus.tx_start, grant_valid, grant_id, bus.tx_data, err_timeout}),
            64'({exp_ready, m_start, (m_owner >= 0), 2'(m_id), m_data, m_err}));
   endtask

   task automatic advance();
      @(posedge clk);
      if (reset === 1'b1) model_edge();
      else model_reset();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      model_reset();
      settle();
      check("reset_outputs",
            64'({bus.req_ready, bus.tx_start, grant_valid, grant_id, bus.tx_data, err_timeout}),
            64'(17'd0));
      advance();
      settle();
      advance();
      reset = 1'b1;
   endtask

   task automatic add_row(input bit e, input logic [3:0] v, input bit b, input bit d,
                          input logic [3:0] rdy, input bit st, input bit gv,
                          input logic [1:0] gid, input logic [DW-1:0] dat);
      vec_t r;
      r.en = e; r.valid = v; r.busy = b; r.done = d;
      r.ready = rdy; r.start = st; r.gv = gv; r.gid = gid; r.data = dat;
      tbl.push_back(r);
   endtask

   task automatic run_table(input string name);
      foreach (tbl[i]) begin
         en = tbl[i].en; rv = tbl[i].valid; tb_busy = tbl[i].busy; tb_done = tbl[i].done;
         settle();
         check($sformatf("%s_row%0d", name, i),
               64'({bus.req_ready, bus.tx_start, grant_valid, grant_id, bus.tx_data, err_timeout}),
               64'({tbl[i].ready, tbl[i].start, tbl[i].gv, tbl[i].gid, tbl[i].data, 1'b0}));
         advance();
      end
      tbl.delete();
   endtask

   // Waits (bounded) for the start pulse, checks the owner, then plays a frame.
   task automatic frame(input int exp_id, input int busy_len, input string name);
      bit seen;
      seen = 0; tb_busy = 1'b0; tb_done = 1'b0;
      for (int k = 0; k < 8 && !seen; k++) begin
         settle();
         if (bus.tx_start === 1'b1) begin
            seen = 1;
            check(name, 64'(grant_id), 64'(exp_id));
         end
         advance();
      end
      check({name, "_start_seen"}, 64'(seen), 64'(1));
      tb_busy = 1'b1;
      repeat (busy_len) begin settle(); advance(); end
      tb_busy = 1'b0; tb_done = 1'b1;
      settle(); advance();
      tb_done = 1'b0;
   endtask

   initial begin
      #1ms;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit seen;
      bit got;
      int cnt;
      int busy_pct;

      reset = 1'b0; en = 1'b1; rv = '0; tb_busy = 1'b0; tb_done = 1'b0;
      for (int i = 0; i < N; i++) src_data[i] = '0;
      model_reset();
      @(negedge clk);
      do_reset();

      // single request from source 0
      src_data[0] = 8'h5A;
      add_row(1, 4'b0001, 0, 0, 4'b0001, 0, 0, 2'd0, 8'h00);
      add_row(1, 4'b0000, 0, 0, 4'b0000, 1, 1, 2'd0, 8'h5A);
      add_row(1, 4'b0000, 0, 0, 4'b0000, 0, 1, 2'd0, 8'h5A);
      for (int i = 0; i < 8; i++) add_row(1, 4'b0000, 1, 0, 4'b0000, 0, 1, 2'd0, 8'h5A);
      add_row(1, 4'b0000, 0, 1, 4'b0000, 0, 1, 2'd0, 8'h5A);
      add_row(1, 4'b0000, 0, 0, 4'b0000, 0, 0, 2'd0, 8'h5A);
      run_table("single");

      // fairness from a fresh pointer
      do_reset();
      for (int i = 0; i < N; i++) src_data[i] = 8'(8'h10 + i);
      rv = 4'b1111;
      frame(0, 2, "fair_a0"); frame(1, 2, "fair_a1"); frame(2, 2, "fair_a2");
      frame(3, 2, "fair_a3"); frame(0, 2, "fair_a4");
      rv = 4'b1101;
      frame(2, 2, "fair_b0"); frame(3, 2, "fair_b1"); frame(0, 2, "fair_b2");
      frame(2, 2, "fair_b3");
      rv = 4'b0000;

      // watchdog: tx path never answers
      rv = 4'b1001; seen = 0;
      for (int k = 0; k < 8 && !seen; k++) begin
         settle();
         if (bus.tx_start === 1'b1) begin
            seen = 1;
            check("wd_grant_id", 64'(grant_id), 64'(3));
         end
         advance();
      end
      check("wd_start_seen", 64'(seen), 64'(1));
      cnt = 0; got = 0;
      for (int k = 0; k < 40 && !got; k++) begin
         settle();
         cnt++;
         if (err_timeout === 1'b1) begin
            got = 1;
            // TO silent WAIT_BUSY cycles, then the registered pulse one cycle later
            check("wd_delay", 64'(cnt), 64'(TO + 1));
            check("wd_grant_valid", 64'(grant_valid), 64'(0));
            check("wd_next_ready", 64'(bus.req_ready), 64'(4'b0001));
         end
         advance();
      end
      check("wd_err_seen", 64'(got), 64'(1));
      rv = 4'b0000;
      settle();
      check("wd_next_start", 64'(bus.tx_start), 64'(1));
      check("wd_next_id", 64'(grant_id), 64'(0));
      advance();
      tb_done = 1'b1; settle(); advance(); tb_done = 1'b0;

      // reset while in WAIT_DONE
      rv = 4'b0100;
      seen = 0;
      for (int k = 0; k < 8 && !seen; k++) begin
         settle();
         if (bus.tx_start === 1'b1) seen = 1;
         advance();
      end
      check("rst_pre_start_seen", 64'(seen), 64'(1));
      rv = 4'b0010; tb_busy = 1'b1;
      repeat (3) begin settle(); advance(); end
      #3 reset = 1'b0;
      #1;
      check("rst_async_outputs",
            64'({bus.req_ready, bus.tx_start, grant_valid, grant_id, bus.tx_data, err_timeout}),
            64'(17'd0));
      model_reset();
      @(negedge clk);
      tb_busy = 1'b0;
      settle(); advance();
      reset = 1'b1;
      frame(1, 2, "rst_regrant");
      rv = 4'b0000;

      // en gating
      src_data[2] = 8'h3C; rv = 4'b0100; en = 1'b0;
      repeat (20) begin
         settle();
         check("en_low_ready", 64'(bus.req_ready), 64'(0));
         advance();
      end
      en = 1'b1;
      settle();
      check("en_high_ready", 64'(bus.req_ready), 64'(4'b0100));
      advance();
      rv = 4'b0000;
      settle();
      check("en_start", 64'(bus.tx_start), 64'(1));
      advance();
      tb_busy = 1'b1; settle(); advance();
      en = 1'b0; settle(); advance();
      tb_busy = 1'b0; tb_done = 1'b1;
      settle();
      check("en_low_inflight", 64'(grant_valid), 64'(1));
      advance();
      tb_done = 1'b0;
      settle();
      check("en_low_frame_done", 64'(grant_valid), 64'(0));
      advance();
      en = 1'b1;

      // short frame: done together with busy in the first WAIT_BUSY cycle
      src_data[1] = 8'hC3;
      add_row(1, 4'b0010, 0, 0, 4'b0010, 0, 0, 2'd2, 8'h3C);
      add_row(1, 4'b0000, 0, 0, 4'b0000, 1, 1, 2'd1, 8'hC3);
      add_row(1, 4'b0000, 1, 1, 4'b0000, 0, 1, 2'd1, 8'hC3);
      add_row(1, 4'b0010, 0, 0, 4'b0010, 0, 0, 2'd1, 8'hC3);
      add_row(1, 4'b0000, 0, 0, 4'b0000, 1, 1, 2'd1, 8'hC3);
      add_row(1, 4'b0000, 0, 1, 4'b0000, 0, 1, 2'd1, 8'hC3);
      add_row(1, 4'b0000, 0, 0, 4'b0000, 0, 0, 2'd1, 8'hC3);
      run_table("short");

      // randomized traffic with a randomly behaving tx path
      busy_pct = 30;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         if (cyc % 250 == 0) busy_pct = ($urandom_range(0, 1) == 0) ? 0 : 30;
         en = ($urandom_range(0, 9) != 0);
         for (int i = 0; i < N; i++) begin
            if (rv[i] == 1'b0 && $urandom_range(0, 3) == 0) begin
               rv[i] = 1'b1;
               src_data[i] = 8'($urandom);
            end
         end
         tb_busy = ($urandom_range(0, 99) < busy_pct);
         tb_done = ($urandom_range(0, 11) == 0);
         settle();
         advance();
         if (m_last_acc >= 0) rv[m_last_acc] = 1'b0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
